// File: rtl/mem_bus_pkg.sv
// Shared types for the word-bus initiator: access sizes, FSM states and bus geometry.
package mem_bus_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_e;

endpackage

// File: rtl/mem_bus_master_if.sv
// Core-side request/response channel of the memory bus initiator.
interface mem_bus_master_if;
    // A request transfers on a clock edge where req_valid & req_ready; the core holds
    // every req_* field stable while req_valid is high. resp_valid is a single-cycle pulse
    // with no backpressure, and resp_rdata/resp_err hold until the next response.
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane extraction (with extension) and sub-word merge for one 32-bit word.
module mem_lane_align
    import mem_bus_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [31:0] shifted;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        shifted  = word >> {lane, 3'b000};
        byte_val = shifted[7:0];
        half_val = lane[1] ? word[31:16] : word[15:0];
        rdata    = word;
        merged   = word;
        case (size)
            SZ_BYTE: begin
                rdata = is_unsigned ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                rdata = is_unsigned ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: begin
                rdata  = word;
                merged = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_master.sv
// Byte-addressed load/store initiator for a word-wide tri-state memory bus.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int MEM_SIZE = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_master_if.slave   core,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_addr,
    inout  wire  [31:0]       bus,
    output state_e            dbg_state
);

    state_e      state;
    logic        we_q;
    logic        uns_q;
    size_e       size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic [31:0] lane_rdata;
    logic [31:0] lane_merged;
    logic        req_bad;
    logic        bus_oe;
    size_e       req_size;

    assign req_size = size_e'(core.req_size);

    always_comb begin
        req_bad = (core.req_addr >= 32'(MEM_SIZE));
        case (req_size)
            SZ_BYTE: ;
            SZ_HALF: if (core.req_addr[0])            req_bad = 1'b1;
            SZ_WORD: if (core.req_addr[1:0] != 2'b00) req_bad = 1'b1;
            default: req_bad = 1'b1;
        endcase
    end

    // Strobes and the bus enable come straight from the state register.
    assign mem_rd    = (state == READ)  || (state == RMW_RD);
    assign bus_oe    = (state == WRITE) || (state == RMW_WR);
    assign mem_wr    = bus_oe;
    assign bus       = bus_oe ? wdata_q : 'z;
    assign mem_addr  = (state == IDLE) ? 32'h0 : {2'b00, addr_q[31:2]};
    assign dbg_state = state;

    assign core.req_ready  = (state == IDLE);
    assign core.resp_valid = (state == RESP);
    assign core.resp_rdata = resp_rdata_q;
    assign core.resp_err   = resp_err_q;

    mem_lane_align u_align (
        .word        (bus),
        .wdata       (wdata_q),
        .lane        (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rdata       (lane_rdata),
        .merged      (lane_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= SZ_BYTE;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (core.req_valid) begin
                        we_q    <= core.req_we;
                        uns_q   <= core.req_unsigned;
                        size_q  <= req_size;
                        addr_q  <= core.req_addr;
                        wdata_q <= core.req_wdata;
                        if (req_bad) begin
                            resp_rdata_q <= 32'h0;
                            resp_err_q   <= 1'b1;
                            state        <= RESP;
                        end else if (!core.req_we) begin
                            state <= READ;
                        end else if (req_size == SZ_WORD) begin
                            state <= WRITE;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                READ: begin
                    resp_rdata_q <= lane_rdata;
                    resp_err_q   <= 1'b0;
                    state        <= RESP;
                end
                RMW_RD: begin
                    // wdata_q is reused to hold the merged word for the write-back.
                    wdata_q <= lane_merged;
                    state   <= RMW_WR;
                end
                WRITE, RMW_WR: begin
                    resp_rdata_q <= 32'h0;
                    resp_err_q   <= 1'b0;
                    state        <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench: mem_bus_master against a word memory and a byte-array reference model.
`timescale 1ns/1ps
module tb_mem_bus_master;
    import mem_bus_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    wire  [31:0] bus;
    state_e      dbg_state;

    mem_bus_master_if ifc();

    mem_bus_master #(.MEM_SIZE(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .core      (ifc),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Word memory on the far side of the bus
    logic [31:0] mem [16];
    assign bus = mem_rd ? mem[mem_addr[3:0]] : 'z;
    always @(posedge clk) if (mem_wr) mem[mem_addr[3:0]] <= bus;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;

    always @(negedge clk) begin
        if (mem_rd) rd_cnt++;
        if (mem_wr) wr_cnt++;
        if (rst === 1'b0) begin
            checks++;
            if (mem_rd && mem_wr) begin
                failures++;
                $display("FAIL strobe_exclusive t=%0t mem_rd=%0b mem_wr=%0b required not both", $time, mem_rd, mem_wr);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_bytes [64];
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat, exp_wr, exp_rd;
    logic [31:0] obs_rdata;
    logic        obs_err, obs_after;
    int          obs_lat, obs_wr, obs_rd;
    logic [31:0] exp_q [$];

    function automatic void model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                  input logic uns, input logic [31:0] wdata);
        int n;
        logic [31:0] val;
        n = 1 << size;
        exp_err = (size == 2'b11) || (addr >= 64) || (n == 2 && addr % 2 != 0) || (n == 4 && addr % 4 != 0);
        exp_rdata = 32'h0;
        exp_wr = 0;
        exp_rd = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (we) begin
            for (int i = 0; i < n; i++) ref_bytes[addr + i] = wdata[8*i +: 8];
            exp_lat = (n == 4) ? 2 : 3;
            exp_wr  = 1;
            exp_rd  = (n == 4) ? 0 : 1;
        end else begin
            val = 32'h0;
            for (int i = 0; i < n; i++) val[8*i +: 8] = ref_bytes[addr + i];
            if (!uns && n < 4 && val[8*n-1])
                for (int i = n; i < 4; i++) val[8*i +: 8] = 8'hFF;
            exp_rdata = val;
            exp_lat   = 2;
            exp_rd    = 1;
        end
    endfunction

    // ---------------- driver ----------------
    task automatic set_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata);
        ifc.req_we       = we;
        ifc.req_addr     = addr;
        ifc.req_size     = size;
        ifc.req_unsigned = uns;
        ifc.req_wdata    = wdata;
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata);
        int wr0, rd0, cyc;
        model(we, addr, size, uns, wdata);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        @(negedge clk);
        set_req(we, addr, size, uns, wdata);
        ifc.req_valid = 1'b1;
        cyc = 0;
        while (!ifc.req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        ifc.req_valid = 1'b0;
        cyc = 1;
        while (!ifc.resp_valid && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        obs_lat   = ifc.resp_valid ? cyc : -1;
        obs_rdata = ifc.resp_rdata;
        obs_err   = ifc.resp_err;
        @(negedge clk);
        obs_after = ifc.resp_valid;
        obs_wr    = wr_cnt - wr0;
        obs_rd    = rd_cnt - rd0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        ifc.req_valid = 1'b0;
        set_req(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ifc.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b want=1", ifc.req_ready); end
        checks++; if (ifc.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%0b want=0", ifc.resp_valid); end
        checks++; if (ifc.resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", ifc.resp_rdata); end
        checks++; if (ifc.resp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b want=0", ifc.resp_err); end
        checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%0b%0b want=00", mem_rd, mem_wr); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); end
    endtask

    task automatic test_word();
        xact(1'b1, 32'h08, 2'b10, 1'b0, 32'hDEADBEEF);
        checks++; if (obs_err !== 1'b0 || obs_lat != 2) begin failures++; $display("FAIL word_store err=%0b lat=%0d want err=0 lat=2", obs_err, obs_lat); end
        checks++; if (obs_wr != 1 || obs_rd != 0) begin failures++; $display("FAIL word_store_pulses wr=%0d rd=%0d want 1/0", obs_wr, obs_rd); end
        checks++; if (obs_after !== 1'b0) begin failures++; $display("FAIL resp_one_cycle got=%0b want=0", obs_after); end
        xact(1'b0, 32'h08, 2'b10, 1'b0, 32'h0);
        checks++; if (obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin failures++; $display("FAIL word_load got=%h err=%0b want=deadbeef err=0", obs_rdata, obs_err); end
        checks++; if (obs_lat != 2) begin failures++; $display("FAIL word_load_lat got=%0d want=2", obs_lat); end
    endtask

    task automatic test_byte_rmw();
        xact(1'b1, 32'h09, 2'b00, 1'b0, 32'h00000080);
        checks++; if (obs_lat != 3 || obs_wr != 1 || obs_rd != 1) begin failures++; $display("FAIL byte_store lat=%0d wr=%0d rd=%0d want 3/1/1", obs_lat, obs_wr, obs_rd); end
        checks++; if (mem[2] !== 32'hDEAD80EF) begin failures++; $display("FAIL byte_store_mem got=%h want=dead80ef", mem[2]); end
        xact(1'b0, 32'h09, 2'b00, 1'b0, 32'h0);
        checks++; if (obs_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL byte_load_signed got=%h want=ffffff80", obs_rdata); end
        xact(1'b0, 32'h09, 2'b00, 1'b1, 32'h0);
        checks++; if (obs_rdata !== 32'h00000080) begin failures++; $display("FAIL byte_load_unsigned got=%h want=00000080", obs_rdata); end
    endtask

    task automatic test_half();
        xact(1'b1, 32'h0E, 2'b01, 1'b0, 32'h00001234);
        xact(1'b0, 32'h0E, 2'b01, 1'b0, 32'h0);
        checks++; if (obs_rdata !== 32'h00001234) begin failures++; $display("FAIL half_load_pos got=%h want=00001234", obs_rdata); end
        xact(1'b1, 32'h0E, 2'b01, 1'b0, 32'h0000FFFE);
        xact(1'b0, 32'h0E, 2'b01, 1'b0, 32'h0);
        checks++; if (obs_rdata !== 32'hFFFFFFFE) begin failures++; $display("FAIL half_load_neg got=%h want=fffffffe", obs_rdata); end
        checks++; if (mem[3] !== 32'hFFFE0000) begin failures++; $display("FAIL half_store_mem got=%h want=fffe0000", mem[3]); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4] = '{32'h06, 32'h03, 32'h40, 32'h00};
        logic [1:0]  sizes [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
        logic        wes   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            xact(wes[i], addrs[i], sizes[i], 1'b0, 32'hA5A5A5A5);
            checks++;
            if (obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_lat != 1 || obs_wr != 0 || obs_rd != 0) begin
                failures++;
                $display("FAIL error_case%0d err=%0b rdata=%h lat=%0d wr=%0d rd=%0d want err=1 rdata=0 lat=1 wr=0 rd=0",
                         i, obs_err, obs_rdata, obs_lat, obs_wr, obs_rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        set_req(1'b0, 32'h08, 2'b10, 1'b0, 32'h0);
        ifc.req_valid = 1'b1;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        checks++; if (mem_rd !== 1'b1) begin failures++; $display("FAIL mid_reset_in_read mem_rd=%0b want=1", mem_rd); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ifc.req_ready !== 1'b1 || dbg_state !== IDLE) begin failures++; $display("FAIL mid_reset_idle ready=%0b state=%0d want 1/IDLE", ifc.req_ready, dbg_state); end
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (ifc.resp_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL mid_reset_no_resp got=%0d pulses want=0", seen); end
        xact(1'b0, 32'h08, 2'b10, 1'b0, 32'h0);
        checks++; if (obs_rdata !== 32'hDEAD80EF || obs_rdata !== exp_rdata) begin failures++; $display("FAIL mid_reset_reload got=%h want=dead80ef", obs_rdata); end
    endtask

    task automatic test_back_to_back();
        int acc [$];
        int cyc, idx, nresp;
        logic pend;
        logic [31:0] got;
        for (int i = 0; i < 4; i++) xact(1'b1, 32'h10 + 4*i, 2'b10, 1'b0, $urandom);
        exp_q.delete();
        @(negedge clk);
        set_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        ifc.req_valid = 1'b1;
        cyc = 0; idx = 0; nresp = 0; pend = 1'b0;
        while (nresp < 4 && cyc < 60) begin
            if (ifc.resp_valid) begin
                got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
                checks++;
                if (ifc.resp_rdata !== got || ifc.resp_err !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_data%0d got=%h err=%0b want=%h err=0", nresp, ifc.resp_rdata, ifc.resp_err, got);
                end
                nresp++;
            end
            if (pend) begin
                if (idx < 4) set_req(1'b0, 32'h10 + 4*idx, 2'b10, 1'b0, 32'h0);
                else         ifc.req_valid = 1'b0;
                pend = 1'b0;
            end
            if (ifc.req_valid && ifc.req_ready) begin
                acc.push_back(cyc);
                model(1'b0, 32'h10 + 4*idx, 2'b10, 1'b0, 32'h0);
                exp_q.push_back(exp_rdata);
                idx++;
                pend = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        ifc.req_valid = 1'b0;
        checks++; if (nresp != 4) begin failures++; $display("FAIL b2b_responses got=%0d want=4", nresp); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 3) begin failures++; $display("FAIL b2b_spacing%0d got=%0d want=3", i, acc[i] - acc[i-1]); end
        end
    endtask

    task automatic test_random();
        logic        we, uns;
        logic [1:0]  size;
        logic [31:0] addr, wdata, want;
        for (int t = 0; t < 60; t++) begin
            we    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            size  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            addr  = 32'($urandom_range(0, 16)) * 4;
            if ($urandom_range(0, 9) == 0)  addr += 32'($urandom_range(0, 3));
            else if (size == 2'b00)         addr += 32'($urandom_range(0, 3));
            else if (size == 2'b01)         addr += 32'($urandom_range(0, 1)) * 2;
            wdata = $urandom;
            xact(we, addr, size, uns, wdata);
            checks++;
            if (obs_rdata !== exp_rdata || obs_err !== exp_err || obs_lat != exp_lat || obs_wr != exp_wr || obs_rd != exp_rd) begin
                failures++;
                $display("FAIL rand%0d we=%0b addr=%h size=%0d got rdata=%h err=%0b lat=%0d wr=%0d rd=%0d want rdata=%h err=%0b lat=%0d wr=%0d rd=%0d",
                         t, we, addr, size, obs_rdata, obs_err, obs_lat, obs_wr, obs_rd, exp_rdata, exp_err, exp_lat, exp_wr, exp_rd);
            end
        end
        for (int w = 0; w < 16; w++) begin
            want = {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
            checks++;
            if (mem[w] !== want) begin failures++; $display("FAIL mem_word%0d got=%h want=%h", w, mem[w], want); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int w = 0; w < 16; w++) mem[w] = 32'h0;
        for (int b = 0; b < 64; b++) ref_bytes[b] = 8'h0;
        test_reset();
        test_word();
        test_byte_rmw();
        test_half();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
